// File: rtl/sdram_stream_writer.sv
// sdram_stream_writer: buffers a non-stallable sample stream and drains it into an SDRAM write port over a ring address region
module sdram_stream_writer #(
  parameter int DQ_WIDTH = 16,
  parameter int ADDR_WIDTH = 24,
  parameter int FIFO_AW = 4,
  parameter int ADDR_STEP = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 24'h000000,
  parameter logic [ADDR_WIDTH-1:0] END_ADDR = 24'hFFFFFC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  s_valid,
  input  logic [DQ_WIDTH-1:0]   s_data,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  wr_req,
  output logic [DQ_WIDTH-1:0]   wr_data,
  input  logic                  wr_ack,
  output logic [FIFO_AW:0]      level,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic                  wrapped
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state;
  logic [DQ_WIDTH-1:0] mem [2**FIFO_AW];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic push, pop, drop;
  logic [FIFO_AW:0] level_next;
  logic [DQ_WIDTH-1:0] next_head;
  assign s_ready = ~level[FIFO_AW];
  assign push = s_valid & s_ready;
  assign drop = s_valid & ~s_ready;
  assign pop = (state == REQ) & wr_ack;
  assign level_next = level + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
  // a lone buffered word being popped while a new one arrives means the new sample is the next head
  assign next_head = (level == (FIFO_AW+1)'(1)) ? s_data : mem[rd_ptr + 1'b1];
  // sample storage, unreset: pointers alone define what is valid
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= s_data;
  // FIFO bookkeeping, overflow flag, ring address and write-request FSM
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      wr_req <= 1'b0;
      wr_data <= '0;
      addr <= BASE_ADDR;
      wrapped <= 1'b0;
      overflow <= 1'b0;
      level <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      level <= level_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      overflow <= drop | (overflow & ~ovf_clr);
      wrapped <= pop & (addr == END_ADDR);
      if (pop) addr <= (addr == END_ADDR) ? BASE_ADDR : addr + ADDR_WIDTH'(ADDR_STEP);
      if (state == IDLE) begin
        if (enable && level != '0) begin
          state <= REQ;
          wr_req <= 1'b1;
          wr_data <= mem[rd_ptr];
        end
      end else if (wr_ack) begin
        if (enable && level_next != '0) wr_data <= next_head;
        else begin
          state <= IDLE;
          wr_req <= 1'b0;
        end
      end
    end
endmodule
